// File: rtl/counter_sequencer_if.sv
// Host command channel, SmartCounter control lines and status flags of counter_sequencer.
// Latency/backpressure belong to the sequencer; this file only groups the signals.
interface counter_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_target;
  logic             load;
  logic             enable;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] count_in;
  logic             busy;
  logic             done;
  logic             error;

  // slave: the sequencer itself
  modport slave (
    input  cmd_valid, cmd_start, cmd_target, count_in,
    output cmd_ready, load, enable, data_out, busy, done, error
  );

  // master: host plus the counter it controls
  modport master (
    output cmd_valid, cmd_start, cmd_target, count_in,
    input  cmd_ready, load, enable, data_out, busy, done, error
  );
endinterface

// File: rtl/counter_sequencer.sv
// Loads start into a SmartCounter, enables it until it lands on target, then pulses done (optional abort: COUNTER_SEQ_TIMEOUT_EN).
// Latency: accept -> 1 LOAD cycle -> N=(target-start) mod 2^WIDTH RUN cycles -> 1 DONE cycle -> IDLE.
// Backpressure: cmd_ready is high only in IDLE; commands offered in any other state wait.
module counter_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 300
) (
  input  logic          clk,
  input  logic          reset,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A full wrap must finish before the abort may fire.
  if (TIMEOUT <= (1 << WIDTH)) begin : g_timeout_check
    $error("counter_sequencer: TIMEOUT must exceed 2**WIDTH");
  end

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] target_q;
  logic             accept;
  logic             hit;
  logic             timeout_hit;

  assign accept = bus.cmd_valid && (state_q == IDLE);
  // Stop one count early so the last enabled edge lands exactly on target.
  assign hit    = (bus.count_in == (target_q - WIDTH'(1)));

`ifdef COUNTER_SEQ_TIMEOUT_EN
  localparam int RCW = $clog2(TIMEOUT + 1);

  logic [RCW-1:0] run_cnt_q;
  logic           err_q;

  assign timeout_hit = (run_cnt_q == RCW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == RUN) begin
        run_cnt_q <= run_cnt_q + RCW'(1);
      end else begin
        run_cnt_q <= '0;
      end
      // Set only for the DONE cycle that follows an aborted RUN.
      err_q <= (state_q == RUN) && timeout_hit && !hit;
    end
  end

  assign bus.error = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.error   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = (start_q == target_q) ? DONE : RUN;
      end
      RUN: begin
        if (hit || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q  <= '0;
      target_q <= '0;
    end else if (accept) begin
      start_q  <= bus.cmd_start;
      target_q <= bus.cmd_target;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.load      = (state_q == LOAD);
  assign bus.enable    = (state_q == RUN);
  assign bus.busy      = (state_q == LOAD) || (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.data_out  = start_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: SmartCounter model plus per-command waveform expectations derived from start/target.
module tb_counter_sequencer;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

  counter_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SmartCounter model: load has priority, +1 per enabled edge, natural wrap.
  logic [WIDTH-1:0] cnt = '0;
  logic             cnt_stuck = 1'b0;
  always @(posedge clk) begin
    if (bus.load) cnt <= bus.data_out;
    else if (bus.enable && !cnt_stuck) cnt <= cnt + 8'd1;
  end
  assign bus.count_in = cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a negedge with cmd_ready high, offers the command, returns in the LOAD cycle.
  task automatic issue(input int s, input int t, input bit hold);
    int k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("issue.ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_start  = s[7:0];
    bus.cmd_target = t[7:0];
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // Called in the LOAD cycle; walks LOAD, N RUN cycles, DONE and the following IDLE cycle.
  task automatic check_body(input int s, input int t);
    int n;
    n = (t - s) & 255;
    chk("load.load",  {31'd0, bus.load},      32'd1);
    chk("load.en",    {31'd0, bus.enable},    32'd0);
    chk("load.busy",  {31'd0, bus.busy},      32'd1);
    chk("load.rdy",   {31'd0, bus.cmd_ready}, 32'd0);
    chk("load.done",  {31'd0, bus.done},      32'd0);
    chk("load.data",  {24'd0, bus.data_out},  s);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("run.en",    {31'd0, bus.enable},    32'd1);
      chk("run.load",  {31'd0, bus.load},      32'd0);
      chk("run.done",  {31'd0, bus.done},      32'd0);
      chk("run.rdy",   {31'd0, bus.cmd_ready}, 32'd0);
      chk("run.count", {24'd0, bus.count_in},  (s + i) & 255);
    end
    @(negedge clk);
    chk("done.done",  {31'd0, bus.done},      32'd1);
    chk("done.err",   {31'd0, bus.error},     32'd0);
    chk("done.en",    {31'd0, bus.enable},    32'd0);
    chk("done.busy",  {31'd0, bus.busy},      32'd0);
    chk("done.rdy",   {31'd0, bus.cmd_ready}, 32'd0);
    chk("done.count", {24'd0, bus.count_in},  t);
    @(negedge clk);
    chk("idle.rdy",   {31'd0, bus.cmd_ready}, 32'd1);
    chk("idle.done",  {31'd0, bus.done},      32'd0);
    chk("idle.busy",  {31'd0, bus.busy},      32'd0);
    chk("idle.count", {24'd0, bus.count_in},  t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    int s, t;
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_start  = '0;
    bus.cmd_target = '0;
    repeat (2) @(negedge clk);
    chk("rst.rdy",  {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst.load", {31'd0, bus.load},      32'd0);
    chk("rst.en",   {31'd0, bus.enable},    32'd0);
    chk("rst.busy", {31'd0, bus.busy},      32'd0);
    chk("rst.done", {31'd0, bus.done},      32'd0);
    chk("rst.err",  {31'd0, bus.error},     32'd0);
    chk("rst.data", {24'd0, bus.data_out},  32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(10, 14, 1'b0);  check_body(10, 14);
    issue(20, 20, 1'b0);  check_body(20, 20);
    issue(250, 3, 1'b0);  check_body(250, 3);
    issue(255, 0, 1'b0);  check_body(255, 0);

    // Second command held valid through the first; accepted in the IDLE cycle after done.
    issue(40, 45, 1'b1);
    bus.cmd_start  = 8'd60;
    bus.cmd_target = 8'd62;
    check_body(40, 45);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_body(60, 62);

    for (int r = 0; r < 8; r++) begin
      s = int'($urandom_range(0, 255));
      t = ($urandom_range(0, 3) == 0) ? s : int'($urandom_range(0, 255));
      issue(s, t, 1'b0);
      check_body(s, t);
    end

    // Reset in the middle of RUN drops everything without a done pulse.
    issue(0, 100, 1'b0);
    repeat (30) @(negedge clk);
    chk("mid.en_before", {31'd0, bus.enable}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid.en",   {31'd0, bus.enable},    32'd0);
    chk("mid.busy", {31'd0, bus.busy},      32'd0);
    chk("mid.rdy",  {31'd0, bus.cmd_ready}, 32'd1);
    chk("mid.done", {31'd0, bus.done},      32'd0);
    chk("mid.data", {24'd0, bus.data_out},  32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid.nodone", {31'd0, bus.done}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    issue(7, 9, 1'b0);  check_body(7, 9);

`ifdef COUNTER_SEQ_TIMEOUT_EN
    // Counter ignores enable, so target is never reached and the RUN limit fires.
    cnt_stuck = 1'b1;
    issue(5, 200, 1'b0);
    chk("to.load", {31'd0, bus.load}, 32'd1);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      chk("to.en",   {31'd0, bus.enable}, 32'd1);
      chk("to.done", {31'd0, bus.done},   32'd0);
    end
    @(negedge clk);
    chk("to.done_pulse", {31'd0, bus.done},  32'd1);
    chk("to.err_pulse",  {31'd0, bus.error}, 32'd1);
    chk("to.en_off",     {31'd0, bus.enable}, 32'd0);
    @(negedge clk);
    chk("to.idle_rdy",   {31'd0, bus.cmd_ready}, 32'd1);
    chk("to.idle_err",   {31'd0, bus.error},     32'd0);
    cnt_stuck = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
